// File: rtl/lsu_align.sv
// lsu_align: RV32 load/store alignment unit.
// Decodes size/sign from funct3, drives a byte-addressed memory port and
// returns extended load data. Misaligned half/word accesses are split into
// sequential byte accesses unless LSU_MISALIGN_TRAP_EN is defined, in which
// case they complete immediately with resp_err=1 and no memory access.
module lsu_align #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_len,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                split_q, split_d;
  logic                err_q, err_d;
  logic [1:0]          k_q, k_d;
  logic [1:0]          last_q, last_d;

  logic                legal;
  logic                misal;
  logic                sext;

  // Request decode: funct3 legality and natural-alignment check.
  always_comb begin
    if (req_we) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
    else        legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  assign req_ready = (state_q == IDLE);
  assign sext      = ~f3_q[2];

  // Next-state, memory port drive, load assembly and response formatting.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    split_d    = split_q;
    err_d      = err_q;
    k_d        = k_q;
    last_d     = last_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_len    = 2'b00;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          asm_d   = '0;
          k_d     = 2'd0;
          split_d = misal;
          err_d   = ~legal;
          // ops-1: a split access issues one byte op per byte of the size
          last_d  = misal ? (req_funct3[1] ? 2'd3 : 2'd1) : 2'd0;
          if (!legal) state_d = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
          else state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_we = we_q;
        if (split_q) begin
          mem_addr  = addr_q + ADDR_W'(k_q);
          mem_len   = 2'b00;
          mem_wdata = DATA_W'(wdata_q[{k_q, 3'b000} +: 8]);
          if (!we_q) asm_d[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
        end else begin
          mem_addr  = addr_q;
          mem_len   = f3_q[1] ? 2'b11 : (f3_q[0] ? 2'b01 : 2'b00);
          mem_wdata = wdata_q;
          if (!we_q) asm_d = mem_rdata;
        end
        if (k_q == last_q) state_d = DONE;
        else               k_d     = k_q + 2'd1;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) begin
          unique case (f3_q[1:0])
            2'b00:   resp_rdata = {{24{sext & asm_q[7]}},  asm_q[7:0]};
            2'b01:   resp_rdata = {{16{sext & asm_q[15]}}, asm_q[15:0]};
            default: resp_rdata = asm_q;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      split_q <= split_d;
      err_q   <= err_d;
      k_q     <= k_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed testbench for lsu_align with a 64 KiB byte memory model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_len;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:65535];
  int          wcnt = 0;
  int          acnt = 0;
  logic [31:0] wa [0:63];
  logic [1:0]  wl [0:63];

  lsu_align #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_len(mem_len), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] a0, a1, a2, a3;
  assign a0 = mem_addr[15:0];
  assign a1 = a0 + 16'd1;
  assign a2 = a0 + 16'd2;
  assign a3 = a0 + 16'd3;
  assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (mem_addr != 32'h0) acnt <= acnt + 1;
    if (mem_we) begin
      wa[6'(wcnt)] <= mem_addr;
      wl[6'(wcnt)] <= mem_len;
      wcnt <= wcnt + 1;
      mem[a0] <= mem_wdata[7:0];
      if (mem_len != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_len == 2'b11) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; returns data, error, latency from accept edge, write count.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat, output int nw);
    int w0;
    w0 = wcnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("timeout", 32'd0, 32'd1);
    rd = resp_rdata;
    er = resp_err;
    nw = wcnt - w0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nw, w0, a_before, rv;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mwe", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mlen", 32'(mem_len), 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // aligned word store/load
    w0 = wcnt;
    xfer(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, er, lat, nw);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nw", 32'(nw), 32'd1);
    check("sw_len", 32'(wl[6'(w0)]), 32'd3);
    check("sw_addr", wa[6'(w0)], 32'h100);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    xfer(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, nw);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_err", 32'(er), 32'd0);
    check("lw_nw", 32'(nw), 32'd0);
    xfer(1'b0, 3'b001, 32'h100, 32'h0, rd, er, lat, nw);
    check("lh_al_data", rd, 32'hFFFFBEEF);

    // byte sign/zero extension
    xfer(1'b1, 3'b000, 32'h205, 32'hFFFFFF80, rd, er, lat, nw);
    check("sb_lat", 32'(lat), 32'd2);
    xfer(1'b0, 3'b000, 32'h205, 32'h0, rd, er, lat, nw);
    check("lb_data", rd, 32'hFFFFFF80);
    xfer(1'b0, 3'b100, 32'h205, 32'h0, rd, er, lat, nw);
    check("lbu_data", rd, 32'h00000080);

`ifdef LSU_MISALIGN_TRAP_EN
    xfer(1'b1, 3'b010, 32'h1001, 32'hAABBCCDD, rd, er, lat, nw);
    check("trap_sw_lat", 32'(lat), 32'd1);
    check("trap_sw_err", 32'(er), 32'd1);
    check("trap_sw_nw", 32'(nw), 32'd0);
    xfer(1'b0, 3'b001, 32'h3, 32'h0, rd, er, lat, nw);
    check("trap_lh_err", 32'(er), 32'd1);
    check("trap_lh_rdata", rd, 32'd0);
    check("trap_lh_lat", 32'(lat), 32'd1);
`else
    // misaligned word store split into bytes
    w0 = wcnt;
    xfer(1'b1, 3'b010, 32'h1001, 32'hAABBCCDD, rd, er, lat, nw);
    check("msw_lat", 32'(lat), 32'd5);
    check("msw_nw", 32'(nw), 32'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      check("msw_addr", wa[6'(w0 + int'(i))], 32'h1001 + i);
      check("msw_len", 32'(wl[6'(w0 + int'(i))]), 32'd0);
    end
    check("msw_b0", 32'(mem[16'h1001]), 32'hDD);
    check("msw_b3", 32'(mem[16'h1004]), 32'hAA);
    xfer(1'b0, 3'b010, 32'h1001, 32'h0, rd, er, lat, nw);
    check("mlw_data", rd, 32'hAABBCCDD);
    check("mlw_lat", 32'(lat), 32'd5);
    xfer(1'b0, 3'b100, 32'h1004, 32'h0, rd, er, lat, nw);
    check("lbu_1004", rd, 32'h000000AA);

    // misaligned half load
    xfer(1'b1, 3'b000, 32'h3, 32'h34, rd, er, lat, nw);
    xfer(1'b1, 3'b000, 32'h4, 32'hF2, rd, er, lat, nw);
    xfer(1'b0, 3'b001, 32'h3, 32'h0, rd, er, lat, nw);
    check("mlh_data", rd, 32'hFFFFF234);
    check("mlh_lat", 32'(lat), 32'd3);
    xfer(1'b0, 3'b101, 32'h3, 32'h0, rd, er, lat, nw);
    check("mlhu_data", rd, 32'h0000F234);

    // address wrap
    w0 = wcnt;
    xfer(1'b1, 3'b010, 32'hFFFFFFFF, 32'h11223344, rd, er, lat, nw);
    check("wrap_a0", wa[6'(w0)], 32'hFFFFFFFF);
    check("wrap_a1", wa[6'(w0 + 1)], 32'h00000000);
    check("wrap_a3", wa[6'(w0 + 3)], 32'h00000002);
    xfer(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, rd, er, lat, nw);
    check("wrap_lw", rd, 32'h11223344);

    // reset during a split store
    w0 = wcnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h2001; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_mwe", 32'(mem_we), 32'd0);
    check("mrst_maddr", mem_addr, 32'd0);
    check("mrst_mlen", 32'(mem_len), 32'd0);
    check("mrst_rvalid", 32'(resp_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_nw", 32'(wcnt - w0), 32'd2);
    check("mrst_b0", 32'(mem[16'h2001]), 32'h88);
    check("mrst_b1", 32'(mem[16'h2002]), 32'h77);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 0;
    repeat (4) begin
      if (resp_valid) rv++;
      @(posedge clk); #1;
    end
    check("mrst_noresp", 32'(rv), 32'd0);
    check("mrst_nw_after", 32'(wcnt - w0), 32'd2);
`endif

    // illegal funct3
    a_before = acnt;
    xfer(1'b0, 3'b011, 32'h104, 32'h0, rd, er, lat, nw);
    check("ill_ld_lat", 32'(lat), 32'd1);
    check("ill_ld_err", 32'(er), 32'd1);
    check("ill_ld_nw", 32'(nw), 32'd0);
    check("ill_ld_rdata", rd, 32'd0);
    check("ill_ld_addr", 32'(acnt - a_before), 32'd0);
    xfer(1'b1, 3'b100, 32'h104, 32'h1, rd, er, lat, nw);
    check("ill_st_err", 32'(er), 32'd1);
    check("ill_st_nw", 32'(nw), 32'd0);

    // req_valid held while busy is not queued
    w0 = wcnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    check("busy_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("busy_rvalid", 32'(resp_valid), 32'd1);
    check("busy_ready2", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_nw", 32'(wcnt - w0), 32'd1);
    check("busy_idle", 32'(req_ready), 32'd1);
    xfer(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, nw);
    check("busy_lw", rd, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit between the RV32 core's execute stage and the byte-addressed data memory.
- Accepts one load/store request per valid/ready handshake and decodes size and sign from funct3.
- Drives the memory's Addr/DataW/MemRW/LenSel-style port and returns sign- or zero-extended load data.
- Misaligned half/word accesses are split into sequential byte accesses.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 supported

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, LSB-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3 (or misaligned with trap option); valid with resp_valid
- mem_addr  output  ADDR_W  memory byte address
- mem_wdata  output  DATA_W  memory write data
- mem_we  output  1  memory write enable (memory writes on posedge)
- mem_len  output  2  00 byte, 01 half, 11 word; 10 never driven
- mem_rdata  input  DATA_W  memory combinational read data {B+3,B+2,B+1,B}

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_len=00.
  - req_ready=1 (combinational: state==IDLE).
- States: IDLE, ACCESS, DONE.
- IDLE, on req_valid & req_ready:
  - Latch we, funct3, addr, wdata. Size = 1/2/4 from funct3[1:0].
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Illegal -> DONE with err=1, no memory access.
  - Aligned (addr mod size == 0) -> ops=1, mem_len per size.
  - Misaligned -> ops=size, each op a byte access.
  - Go to ACCESS with op counter k=0.
- ACCESS, one op per cycle:
  - Aligned op: mem_addr=base, mem_len=size code, mem_wdata=wdata.
  - Split op: mem_addr=base+k (mod 2^ADDR_W), mem_len=00, mem_wdata[7:0]=wdata byte k.
  - mem_we=req_we for every op cycle.
  - Loads: capture mem_rdata (aligned) or mem_rdata[7:0] into assembly byte k at the clock edge.
  - After the last op -> DONE.
- DONE, one cycle:
  - resp_valid=1.
  - resp_rdata = assembled value; sign-extend for LB/LH, zero-extend for LBU/LHU/LW, 0 for stores.
  - Next state IDLE.
- req_ready=0 in ACCESS and DONE. req_valid during busy is ignored, not queued.
- mem_we=0 in every state except ACCESS.
- Latency, counted from the accept edge:
  - Aligned: resp_valid in cycle 2.
  - Misaligned half: cycle 3.
  - Misaligned word: cycle 5.
  - Illegal: cycle 1.
- Back-to-back: a new request can be accepted in the cycle after DONE.
- Reset mid-ACCESS: aborts immediately, no response. Bytes already written by completed split-store ops stay in memory.
- Address wrap: base+k at 0xFFFFFFFF wraps to 0x00000000.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests perform no memory access; go directly to DONE with resp_err=1, resp_rdata=0 (latency 1).
- Undefined: misaligned requests are split into byte accesses as described; resp_err only for illegal funct3.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 -> one mem_we cycle with mem_len=11; LW resp_rdata=0xDEADBEEF in cycle 2, resp_err=0.
- Memory byte 0x80 @0x205: LB @0x205 -> 0xFFFFFF80; LBU @0x205 -> 0x00000080.
- SW 0xAABBCCDD @0x1001 -> four byte writes 0x1001..0x1004 = DD, CC, BB, AA; resp_valid in cycle 5. Then LW @0x1001 -> 0xAABBCCDD.
- LH @0x0003 with bytes 0x0003=0x34, 0x0004=0xF2 -> resp_rdata=0xFFFFF234 in cycle 3.
- funct3=011 load -> no mem_we, no mem address changes; resp_valid + resp_err=1 in cycle 1. req_valid held during ACCESS -> req_ready=0, no second access.
- Misaligned SW in progress, rst_n low after 2 ops -> outputs at reset values immediately, only bytes 0 and 1 written, no resp_valid. With LSU_MISALIGN_TRAP_EN defined, same SW -> resp_err=1, no writes.
